// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I main controller.
package riscv_mc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_R      = 2'b10;
    localparam logic [1:0] ALUOP_I      = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_RS1   = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
            default:                           is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_mc_decode.sv
// Control-signal decode from controller state and latched opcode.
// Only ir_write, the store retire and the branch pc_src look at live inputs.
module riscv_mc_decode
    import riscv_mc_pkg::*;
(
    input  state_t     state,
    input  logic [6:0] op_q,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ALUSrc,
    output logic [1:0] ALUop,
    output logic       Umux,
    output logic       RegWrite,
    output logic [1:0] MemtoReg
);

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        pc_src   = PC_PLUS4;
        ALUSrc   = 1'b0;
        ALUop    = ALUOP_ADD;
        Umux     = 1'b0;
        RegWrite = 1'b0;
        MemtoReg = WB_ALU;

        // ALU controls stay stable from EXEC through retire so the datapath result holds
        if (state == ST_EXEC || state == ST_MEM || state == ST_WB) begin
            case (op_q)
                OP_R:      ALUop = ALUOP_R;
                OP_I: begin
                    ALUSrc = 1'b1;
                    ALUop  = ALUOP_I;
                end
                OP_BRANCH: ALUop = ALUOP_BRANCH;
                OP_LUI: begin
                    ALUSrc = 1'b1;
                    Umux   = 1'b1;
                end
                default:   ALUSrc = 1'b1;
            endcase
        end

        case (state)
            ST_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
            end
            ST_EXEC: begin
                if (op_q == OP_BRANCH) begin
                    pc_write = 1'b1;
                    pc_src   = branch_taken ? PC_IMM : PC_PLUS4;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (op_q == OP_STORE);
                if (op_q == OP_STORE && mem_ready)
                    pc_write = 1'b1;
            end
            ST_WB: begin
                RegWrite = 1'b1;
                pc_write = 1'b1;
                case (op_q)
                    OP_LOAD: MemtoReg = WB_MEM;
                    OP_JAL: begin
                        MemtoReg = WB_PC4;
                        pc_src   = PC_IMM;
                    end
                    OP_JALR: begin
                        MemtoReg = WB_PC4;
                        pc_src   = PC_RS1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_mc_control.sv
// Multi-cycle main controller: sequencing FSM, memory wait timeout and perf counters.
//  state  | meaning
//  IDLE   | one cycle after reset
//  FETCH  | instruction read, IR loads on mem_ready
//  DECODE | latch opcode, trap if illegal
//  EXEC   | ALU op; branch retires here
//  MEM    | data access; store retires on mem_ready
//  WB     | register write and retire
//  TRAP   | sticky, left only by reset
module riscv_mc_control
    import riscv_mc_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_W   = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ALUSrc,
    output logic [1:0]       ALUop,
    output logic             Umux,
    output logic             RegWrite,
    output logic [1:0]       MemtoReg,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret
);

    localparam logic [TIMEOUT_W-1:0] WAIT_MAX   = '1;
    localparam logic [TIMEOUT_W-1:0] WAIT_LIMIT = TIMEOUT_W'(MEM_TIMEOUT);

    state_t               state;
    logic [6:0]           op_q;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic [1:0]           cause_q;
    logic                 timeout;

    riscv_mc_decode u_decode (
        .state        (state),
        .op_q         (op_q),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .ALUSrc       (ALUSrc),
        .ALUop        (ALUop),
        .Umux         (Umux),
        .RegWrite     (RegWrite),
        .MemtoReg     (MemtoReg)
    );

    // a ready arriving in the terminal wait cycle completes the access instead of trapping
    assign timeout    = (MEM_TIMEOUT != 0) && mem_req && !mem_ready && (wait_cnt == WAIT_LIMIT);
    assign trap       = (state == ST_TRAP);
    assign trap_cause = cause_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            wait_cnt  <= '0;
            cause_q   <= CAUSE_NONE;
            cycle_cnt <= '0;
            instret   <= '0;
        end else begin
            if (state inside {ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB})
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (pc_write)
                instret <= instret + CNT_W'(1);
            if (mem_req && !mem_ready && wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + TIMEOUT_W'(1);

            // transitions into FETCH/MEM override the increment above to restart the wait
            case (state)
                ST_IDLE: begin
                    state    <= ST_FETCH;
                    wait_cnt <= '0;
                end
                ST_FETCH: begin
                    if (mem_ready) begin
                        state <= ST_DECODE;
                    end else if (timeout) begin
                        state   <= ST_TRAP;
                        cause_q <= CAUSE_TIMEOUT;
                    end
                end
                ST_DECODE: begin
                    op_q <= opcode;
                    if (is_legal(opcode)) begin
                        state <= ST_EXEC;
                    end else begin
                        state   <= ST_TRAP;
                        cause_q <= CAUSE_ILLEGAL;
                    end
                end
                ST_EXEC: begin
                    if (op_q == OP_LOAD || op_q == OP_STORE) begin
                        state    <= ST_MEM;
                        wait_cnt <= '0;
                    end else if (op_q == OP_BRANCH) begin
                        state    <= ST_FETCH;
                        wait_cnt <= '0;
                    end else begin
                        state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        if (op_q == OP_STORE) begin
                            state    <= ST_FETCH;
                            wait_cnt <= '0;
                        end else begin
                            state <= ST_WB;
                        end
                    end else if (timeout) begin
                        state   <= ST_TRAP;
                        cause_q <= CAUSE_TIMEOUT;
                    end
                end
                ST_WB: begin
                    state    <= ST_FETCH;
                    wait_cnt <= '0;
                end
                ST_TRAP: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mc_control.sv
// Directed bench for riscv_mc_control with a retire scoreboard.
module tb_riscv_mc_control;

    logic        clk;
    logic        reset;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        ALUSrc;
    logic [1:0]  ALUop;
    logic        Umux;
    logic        RegWrite;
    logic [1:0]  MemtoReg;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] cycle_cnt;
    logic [31:0] instret;

    int total = 0;
    int bad   = 0;
    int exp_instret = 0;
    int exp_cycles  = 0;

    typedef struct {
        logic [6:0] op;
        logic [1:0] pc_src;
        logic       rw;
        logic [1:0] m2r;
        logic [1:0] aluop;
        logic       alusrc;
        logic       umux;
        int         cycles;
    } exp_t;

    exp_t sb[$];

    riscv_mc_control dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .ALUSrc       (ALUSrc),
        .ALUop        (ALUop),
        .Umux         (Umux),
        .RegWrite     (RegWrite),
        .MemtoReg     (MemtoReg),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .cycle_cnt    (cycle_cnt),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // expected retire behaviour, written from the opcode table
    function automatic exp_t model(input logic [6:0] op, input logic bt, input int d);
        exp_t e;
        e.op = op; e.pc_src = 2'b00; e.rw = 1'b1; e.m2r = 2'b00;
        e.aluop = 2'b00; e.alusrc = 1'b1; e.umux = 1'b0; e.cycles = 4;
        case (op)
            7'b0110011: begin e.aluop = 2'b10; e.alusrc = 1'b0; end
            7'b0010011: e.aluop = 2'b11;
            7'b0000011: begin e.m2r = 2'b01; e.cycles = 5 + d; end
            7'b0100011: begin e.rw = 1'b0; e.cycles = 4 + d; end
            7'b1100011: begin
                e.rw = 1'b0; e.aluop = 2'b01; e.alusrc = 1'b0;
                e.pc_src = bt ? 2'b01 : 2'b00; e.cycles = 3;
            end
            7'b1101111: begin e.m2r = 2'b10; e.pc_src = 2'b01; end
            7'b1100111: begin e.m2r = 2'b10; e.pc_src = 2'b10; end
            7'b0110111: e.umux = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    // starts in FETCH one ns after an edge; ends back in FETCH after the retire edge
    task automatic exec_instr(input logic [6:0] op, input logic bt, input int mem_delay);
        exp_t e;
        exp_t got;
        int   cyc;
        int   mwait;
        bit   fetched;
        bit   done;
        bit   rw_early;
        bit   we_seen;
        cyc = 0; mwait = 0; fetched = 0; done = 0; rw_early = 0; we_seen = 0;
        e = model(op, bt, mem_delay);
        sb.push_back(e);
        opcode = op;
        branch_taken = bt;
        while (!done && cyc < 60) begin
            mem_ready = 1'b0;
            #1;
            if (mem_req) begin
                if (!fetched) mem_ready = 1'b1;
                else if (mwait == mem_delay) mem_ready = 1'b1;
                else mwait++;
                #1;
            end
            cyc++;
            if (fetched && mem_req && mem_we) we_seen = 1'b1;
            if (ir_write) fetched = 1'b1;
            if (pc_write) begin
                got = sb.pop_front();
                check($sformatf("pc_src_%b", got.op), {30'd0, pc_src}, {30'd0, got.pc_src});
                check($sformatf("regwrite_%b", got.op), {31'd0, RegWrite}, {31'd0, got.rw});
                check($sformatf("memtoreg_%b", got.op), {30'd0, MemtoReg}, {30'd0, got.m2r});
                check($sformatf("aluop_%b", got.op), {30'd0, ALUop}, {30'd0, got.aluop});
                check($sformatf("alusrc_%b", got.op), {31'd0, ALUSrc}, {31'd0, got.alusrc});
                check($sformatf("umux_%b", got.op), {31'd0, Umux}, {31'd0, got.umux});
                check($sformatf("latency_%b", got.op), cyc, got.cycles);
                done = 1'b1;
            end else if (RegWrite) begin
                rw_early = 1'b1;
            end
            step();
        end
        if (!done) begin
            check($sformatf("retire_seen_%b", op), 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        mem_ready = 1'b0;
        check($sformatf("early_regwrite_%b", op), {31'd0, rw_early}, 32'd0);
        check($sformatf("mem_we_%b", op), {31'd0, we_seen}, {31'd0, (op == 7'b0100011)});
        exp_instret++;
        exp_cycles += e.cycles;
        check($sformatf("instret_%b", op), instret, exp_instret);
        check($sformatf("cycle_cnt_%b", op), cycle_cnt, exp_cycles);
    endtask

    // leaves the DUT in its first FETCH cycle with mem_ready low
    task automatic do_reset();
        reset = 1'b1; mem_ready = 1'b0; opcode = 7'd0; branch_taken = 1'b0;
        step();
        step();
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_trap", {30'd0, trap_cause, trap}, 32'd0);
        check("rst_cycle_cnt", cycle_cnt, 32'd0);
        check("rst_instret", instret, 32'd0);
        reset = 1'b0;
        #1;
        check("idle_mem_req", {31'd0, mem_req}, 32'd0);
        step();
        check("fetch_mem_req", {31'd0, mem_req}, 32'd1);
        check("fetch_mem_we", {31'd0, mem_we}, 32'd0);
        check("fetch_cycle_cnt", cycle_cnt, 32'd0);
        exp_instret = 0;
        exp_cycles  = 0;
    endtask

    initial begin
        bit quiet_bad;
        reset = 1'b1; mem_ready = 1'b0; opcode = 7'd0; branch_taken = 1'b0;

        do_reset();
        exec_instr(7'b0110011, 1'b0, 0);

        do_reset();
        exec_instr(7'b0000011, 1'b0, 3);

        do_reset();
        exec_instr(7'b1100011, 1'b1, 0);
        exec_instr(7'b1100011, 1'b0, 0);
        exec_instr(7'b0100011, 1'b0, 2);
        exec_instr(7'b1101111, 1'b0, 0);
        exec_instr(7'b1100111, 1'b1, 0);
        exec_instr(7'b0110111, 1'b0, 0);
        exec_instr(7'b0010111, 1'b0, 0);
        exec_instr(7'b0010011, 1'b0, 0);
        exec_instr(7'b0000011, 1'b0, 15);

        // illegal opcode
        do_reset();
        opcode = 7'b1111111;
        mem_ready = 1'b1;
        #1;
        check("illegal_ir_write", {31'd0, ir_write}, 32'd1);
        step();
        mem_ready = 1'b0;
        step();
        check("illegal_trap", {31'd0, trap}, 32'd1);
        check("illegal_cause", {30'd0, trap_cause}, 32'd1);
        quiet_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'b1;
            #1;
            if (mem_req || pc_write || ir_write) quiet_bad = 1'b1;
            step();
        end
        check("trap_quiet", {31'd0, quiet_bad}, 32'd0);
        check("trap_sticky", {30'd0, trap_cause, trap}, 32'b011);
        check("trap_cycle_cnt", cycle_cnt, 32'd2);

        // fetch timeout
        do_reset();
        for (int i = 0; i < 15; i++) step();
        check("pre_timeout_trap", {31'd0, trap}, 32'd0);
        check("pre_timeout_req", {31'd0, mem_req}, 32'd1);
        step();
        check("timeout_trap", {31'd0, trap}, 32'd1);
        check("timeout_cause", {30'd0, trap_cause}, 32'd2);
        check("timeout_cycle_cnt", cycle_cnt, 32'd16);

        // ready on the terminal wait cycle completes the fetch
        do_reset();
        for (int i = 0; i < 15; i++) step();
        opcode = 7'b0010011;
        mem_ready = 1'b1;
        #1;
        check("late_ready_ir_write", {31'd0, ir_write}, 32'd1);
        step();
        mem_ready = 1'b0;
        step();
        check("late_ready_no_trap", {30'd0, trap_cause, trap}, 32'd0);

        // reset during a pending memory access
        do_reset();
        opcode = 7'b0000011;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
        step();
        check("mem_pending_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_mem_req", {31'd0, mem_req}, 32'd0);
        check("abort_instret", instret, 32'd0);
        check("abort_cycle_cnt", cycle_cnt, 32'd0);
        step();
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
